// File: rtl/register_write_arbiter_if.sv
// register_write_arbiter_if: requester and output-register signal bundle for register_write_arbiter
interface register_write_arbiter_if #(parameter int WIDTH = 8);
    logic req0, req1, ack0, ack1, reg_en, busy, grant;
    logic [WIDTH-1:0] data0, data1, reg_in;
    modport master (output req0, data0, req1, data1, input ack0, ack1, reg_in, reg_en, busy, grant);
    modport slave (input req0, data0, req1, data1, output ack0, ack1, reg_in, reg_en, busy, grant);
endinterface

// File: rtl/register_write_arbiter.sv
// register_write_arbiter: round-robin two-port writer for a load-on-edge register with setup/hold sequencing
module register_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int SETTLE = 2,
    parameter int HOLD = 1
) (
    input logic clk,
    input logic reset,
    register_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(SETTLE > HOLD ? SETTLE : HOLD) + 1;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] reg_in_n;
    logic last, last_n, grant_n, pick;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        last_n = last;
        grant_n = bus.grant;
        reg_in_n = bus.reg_in;
        pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
        case (state)
            IDLE: if (bus.req0 || bus.req1) begin
                state_n = SETUP;
                cnt_n = CW'(SETTLE);
                last_n = pick;
                grant_n = pick;
                reg_in_n = pick ? bus.data1 : bus.data0;
            end
            SETUP: if (cnt == CW'(1)) begin
                state_n = STROBE;
                cnt_n = CW'(HOLD);
            end else cnt_n = cnt - 1'b1;
            STROBE: if (cnt == CW'(1)) state_n = RELEASE; else cnt_n = cnt - 1'b1;
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // outputs are derived from the next state so every one comes straight from a flop; reg_en is used as a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            last <= 1'b1;
            bus.grant <= 1'b0;
            bus.reg_in <= '0;
            bus.reg_en <= 1'b0;
            bus.busy <= 1'b0;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            last <= last_n;
            bus.grant <= grant_n;
            bus.reg_in <= reg_in_n;
            bus.reg_en <= state_n == STROBE;
            bus.busy <= state_n != IDLE;
            bus.ack0 <= state_n == RELEASE && !grant_n;
            bus.ack1 <= state_n == RELEASE && grant_n;
        end
    end
endmodule

// File: tb/tb_register_write_arbiter.sv
// tb_register_write_arbiter: three instances (SETTLE/HOLD = 2/1, 1/3, 4/1) checked against a write-schedule model
module tb_register_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] r0 = '0, r1 = '0, a0, a1, en, bsy, gr;
    logic [7:0] d0[3], d1[3], rin[3];
    int ml[3];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : u
        register_write_arbiter_if #(.WIDTH(8)) bus ();
        assign bus.req0 = r0[g];
        assign bus.req1 = r1[g];
        assign bus.data0 = d0[g];
        assign bus.data1 = d1[g];
        assign a0[g] = bus.ack0;
        assign a1[g] = bus.ack1;
        assign en[g] = bus.reg_en;
        assign bsy[g] = bus.busy;
        assign gr[g] = bus.grant;
        assign rin[g] = bus.reg_in;
        register_write_arbiter #(.WIDTH(8), .SETTLE(g == 1 ? 1 : (g == 2 ? 4 : 2)), .HOLD(g == 1 ? 3 : 1)) dut (
            .clk(clk), .reset(reset), .bus(bus));
    end
    function automatic int sv(input int k);
        return k == 1 ? 1 : (k == 2 ? 4 : 2);
    endfunction
    function automatic int hv(input int k);
        return k == 1 ? 3 : 1;
    endfunction
    // One full write: requests are already set, DUT idle; expectations follow from the grant offset t
    task automatic do_write(input int k, input bit chg, input bit rearm);
        int s, h, p;
        logic [7:0] d;
        bit xb, xe, xa;
        s = sv(k);
        h = hv(k);
        p = (r0[k] && r1[k]) ? 1 - ml[k] : (r1[k] ? 1 : 0);
        d = p ? d1[k] : d0[k];
        ml[k] = p;
        for (int t = 1; t <= s + h + 2; t++) begin
            @(negedge clk);
            xb = t <= s + h + 1;
            xe = t > s && t <= s + h;
            xa = t == s + h + 1;
            checks += 5;
            if (bsy[k] !== xb) begin errors++; $display("FAIL busy inst%0d t=%0d got %b want %b", k, t, bsy[k], xb); end
            if (en[k] !== xe) begin errors++; $display("FAIL reg_en inst%0d t=%0d got %b want %b", k, t, en[k], xe); end
            if ({a1[k], a0[k]} !== {xa && p == 1, xa && p == 0}) begin
                errors++; $display("FAIL ack inst%0d t=%0d got %b%b want %b%b", k, t, a1[k], a0[k], xa && p == 1, xa && p == 0);
            end
            if (rin[k] !== d) begin errors++; $display("FAIL reg_in inst%0d t=%0d got %h want %h", k, t, rin[k], d); end
            if (gr[k] !== 1'(p)) begin errors++; $display("FAIL grant inst%0d t=%0d got %b want %0d", k, t, gr[k], p); end
            if (chg) begin
                if (p == 1) d1[k] = 8'($urandom); else d0[k] = 8'($urandom);
            end
            if (xa) begin
                if (p == 1) r1[k] = 1'b0; else r0[k] = 1'b0;
            end
        end
        if (rearm) begin
            if (p == 1) begin r1[k] = 1'b1; d1[k] = 8'($urandom); end
            else begin r0[k] = 1'b1; d0[k] = 8'($urandom); end
        end
    endtask
    task automatic test_reset;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bsy[k], en[k], a0[k], a1[k], gr[k], rin[k]} !== 13'b0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d got busy=%b en=%b ack=%b%b grant=%b reg_in=%h want all 0", k, bsy[k], en[k], a1[k], a0[k], gr[k], rin[k]);
            end
            ml[k] = 1;
        end
        reset = 1'b1;
        @(negedge clk);
    endtask
    task automatic test_single;
        d0[0] = 8'hA5;
        r0[0] = 1'b1;
        do_write(0, 0, 0);
    endtask
    task automatic test_tie;
        d1[0] = 8'($urandom);
        r1[0] = 1'b1;
        do_write(0, 0, 0);
        d0[0] = 8'h11;
        d1[0] = 8'h22;
        r0[0] = 1'b1;
        r1[0] = 1'b1;
        do_write(0, 0, 0);
        checks++;
        if (gr[0] !== 1'b0) begin errors++; $display("FAIL tie_first got %b want 0", gr[0]); end
        do_write(0, 0, 0);
        checks++;
        if (gr[0] !== 1'b1 || rin[0] !== 8'h22) begin errors++; $display("FAIL tie_second got grant=%b reg_in=%h want 1/22", gr[0], rin[0]); end
        r0[0] = 1'b1;
        r1[0] = 1'b1;
        do_write(0, 0, 0);
        checks++;
        if (gr[0] !== 1'b0) begin errors++; $display("FAIL tie_again got %b want 0", gr[0]); end
        do_write(0, 0, 0);
    endtask
    task automatic test_round_robin;
        int first;
        d0[0] = 8'($urandom);
        d1[0] = 8'($urandom);
        r0[0] = 1'b1;
        r1[0] = 1'b1;
        first = 1 - ml[0];
        for (int i = 0; i < 8; i++) begin
            do_write(0, 0, 1);
            checks++;
            if (gr[0] !== 1'(first ^ (i & 1))) begin errors++; $display("FAIL rr_alternate write%0d got %b want %0d", i, gr[0], first ^ (i & 1)); end
        end
        r0[0] = 1'b0;
        r1[0] = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_data_stability;
        d1[0] = 8'($urandom);
        r1[0] = 1'b1;
        do_write(0, 1, 0);
    endtask
    task automatic test_reset_mid_strobe;
        d0[0] = 8'($urandom);
        r0[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (en[0] !== 1'b1) begin errors++; $display("FAIL strobe_before_reset got %b want 1", en[0]); end
        reset = 1'b0;
        #1;
        checks++;
        if ({en[0], bsy[0], rin[0], a0[0], a1[0], gr[0]} !== 13'b0) begin
            errors++; $display("FAIL async_reset got en=%b busy=%b reg_in=%h ack=%b%b grant=%b want all 0", en[0], bsy[0], rin[0], a1[0], a0[0], gr[0]);
        end
        r0[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({a0[0], a1[0], bsy[0]} !== 3'b0) begin errors++; $display("FAIL no_ack_in_reset cycle%0d got ack=%b%b busy=%b want 0", i, a1[0], a0[0], bsy[0]); end
        end
        for (int k = 0; k < 3; k++) ml[k] = 1;
        reset = 1'b1;
        d0[0] = 8'($urandom);
        r0[0] = 1'b1;
        do_write(0, 0, 0);
    endtask
    task automatic test_param_sweep;
        int pat;
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                pat = $urandom_range(1, 3);
                d0[k] = 8'($urandom);
                d1[k] = 8'($urandom);
                r0[k] = pat[0];
                r1[k] = pat[1];
                do_write(k, 0, 0);
                if (r0[k] || r1[k]) do_write(k, 0, 0);
                checks++;
                if (bsy[k] !== 1'b0) begin errors++; $display("FAIL sweep_idle inst%0d got %b want 0", k, bsy[k]); end
            end
        end
    endtask
    initial begin
        for (int k = 0; k < 3; k++) begin
            d0[k] = '0;
            d1[k] = '0;
            ml[k] = 1;
        end
        test_reset;
        test_single;
        test_tie;
        test_round_robin;
        test_data_stability;
        test_reset_mid_strobe;
        test_param_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
